// File: rtl/wave_switch_ctrl.sv
// Glitch-free DAC source switching between generators A/B/C.
// Requests (key or dwell timer) wait for a DDS phase wrap, mute to midscale, then advance sel.
module wave_switch_ctrl #(
  parameter int unsigned   DW        = 14,
  parameter int unsigned   MUTE_CYC  = 16,
  parameter int unsigned   DWELL_CYC = 50000000,
  parameter int unsigned   WRAP_TO   = 65536,
  parameter logic [DW-1:0] MID       = {1'b1, {(DW-1){1'b0}}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_next,
  input  logic          key_mode,
  input  logic          phase_wrap,
  input  logic [DW-1:0] da_ina,
  input  logic [DW-1:0] da_inb,
  input  logic [DW-1:0] da_inc,
  output logic [DW-1:0] da_out,
  output logic [1:0]    sel,
  output logic          auto_mode,
  output logic          busy
);

  localparam int unsigned DWELL_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int unsigned MUTE_W  = (MUTE_CYC > 1)  ? $clog2(MUTE_CYC)  : 1;
  localparam int unsigned TO_W    = (WRAP_TO > 1)   ? $clog2(WRAP_TO)   : 1;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);
  localparam logic [MUTE_W-1:0]  MUTE_LAST  = MUTE_W'(MUTE_CYC - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(WRAP_TO - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WRAP = 2'd1,
    MUTE      = 2'd2,
    SWITCH    = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                req;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [MUTE_W-1:0]   mute_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [DW-1:0]       src;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a wrap coincident with the request is not seen since IDLE ignores phase_wrap
  always_comb begin
    state_next = state;
    req        = 1'b0;
    case (state)
      IDLE: begin
        req = key_next | (auto_mode & (dwell_cnt == DWELL_LAST));
        if (req) state_next = WAIT_WRAP;
      end
      WAIT_WRAP: if (phase_wrap || (to_cnt == TO_LAST)) state_next = MUTE;
      MUTE:      if (mute_cnt == MUTE_LAST) state_next = SWITCH;
      SWITCH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Counters only advance while staying in their state, so they never pass their limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt   <= '0;
      mute_cnt <= '0;
    end else begin
      if (state == IDLE && req)
        to_cnt <= '0;
      else if (state == WAIT_WRAP && state_next == WAIT_WRAP)
        to_cnt <= to_cnt + TO_W'(1);

      if (state == WAIT_WRAP && state_next != WAIT_WRAP)
        mute_cnt <= '0;
      else if (state == MUTE && state_next == MUTE)
        mute_cnt <= mute_cnt + MUTE_W'(1);
    end
  end

  // Dwell timer and mode toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      auto_mode <= 1'b0;
    end else begin
      if (key_mode) auto_mode <= ~auto_mode;

      if (key_mode || state != IDLE || !auto_mode || req)
        dwell_cnt <= '0;
      else
        dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

  always_comb begin
    src = da_ina;
    case (sel)
      2'd1:    src = da_inb;
      2'd2:    src = da_inc;
      default: src = da_ina;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= 2'd0;
      busy   <= 1'b0;
      da_out <= MID;
    end else begin
      if (state == SWITCH) sel <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
      busy   <= (state_next != IDLE);
      da_out <= (state == MUTE || state == SWITCH) ? MID : src;
    end
  end

endmodule
